int_ctrl: RTL and testbench

- Memory-mapped interrupt controller between the device IRQ lines (timer0, timer1, external interrupt, spares) and the CPU's HWInt input.
- Latches interrupt requests as level- or edge-triggered and masks them per source.
- Tracks nested in-service priority so the CPU only sees requests that outrank the handler now running.
- Sits behind the bridge as a slave device, like the timers; its hwint output replaces the raw HWInt vector.

---
 rtl/int_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_int_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// int_ctrl: memory-mapped interrupt controller sitting between device IRQ
// lines and the CPU. Latches level/edge requests, masks them per source,
// and tracks nested in-service priority so the CPU only sees requests that
// outrank the handler currently running. Index 0 is the highest priority.
//
// Register map (addr[1:0]):
//   0 IE   rw  per-source enable
//   1 MODE rw  1 = edge, 0 = level
//   2 PEND r   level bits read-only, edge bits write-1-to-clear
//   3 ISR  r   {31: any, [N_SRC+7:8] mask, [2:0] top index}; any write = EOI
module int_ctrl #(
    parameter int               N_SRC    = 6,
    parameter logic [N_SRC-1:0] IE_RESET = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_in,
    input  logic [29:0]      addr,
    input  logic             we,
    input  logic [31:0]      din,
    output logic [31:0]      dout,
    input  logic             irq_taken,
    output logic [N_SRC-1:0] hwint,
    output logic             irq_req
);

    localparam logic [1:0] A_IE   = 2'd0;
    localparam logic [1:0] A_MODE = 2'd1;
    localparam logic [1:0] A_PEND = 2'd2;
    localparam logic [1:0] A_ISR  = 2'd3;

    logic [N_SRC-1:0] ie;
    logic [N_SRC-1:0] mode;
    logic [N_SRC-1:0] pend;
    logic [N_SRC-1:0] isr;
    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] prev;

    logic [1:0]       reg_sel;
    logic [N_SRC-1:0] wdata;
    logic             wr_ie;
    logic             wr_mode;
    logic             wr_pend;
    logic             wr_eoi;

    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] edge_next;
    logic [N_SRC-1:0] pend_next;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] pmask;
    logic [N_SRC-1:0] isr_low_oh;
    logic [N_SRC-1:0] win_therm;
    logic [N_SRC-1:0] win_oh;
    logic [N_SRC-1:0] isr_next;
    logic             taken_ok;
    logic             isr_any;
    logic [2:0]       isr_idx;

    // Only the low address bits and the low data bits carry meaning here;
    // the bridge has already done chip select.
    logic unused_bits;
    assign unused_bits = ^{addr[29:2], din[31:N_SRC]};

    assign reg_sel = addr[1:0];
    assign wdata   = din[N_SRC-1:0];
    assign wr_ie   = we && (reg_sel == A_IE);
    assign wr_mode = we && (reg_sel == A_MODE);
    assign wr_pend = we && (reg_sel == A_PEND);
    assign wr_eoi  = we && (reg_sel == A_ISR);

    // Thermometer from the lowest set bit upward: bit i is 1 when any bit
    // at index <= i is set. Used both as the priority mask and as a
    // building block for the lowest-set one-hot.
    function automatic logic [N_SRC-1:0] therm_up(input logic [N_SRC-1:0] v);
        logic [N_SRC-1:0] t;
        logic             seen;
        t    = '0;
        seen = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            seen = seen | v[i];
            t[i] = seen;
        end
        return t;
    endfunction

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [2:0] low_index(input logic [N_SRC-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Priority mask from the in-service set and the winning request from
    // the registered hwint vector.
    always_comb begin
        pmask      = therm_up(isr);
        isr_low_oh = pmask & ~(pmask << 1);
        win_therm  = therm_up(hwint);
        win_oh     = win_therm & ~(win_therm << 1);
        isr_any    = |isr;
        isr_idx    = low_index(isr);
        taken_ok   = irq_taken && (|hwint);
    end

    // Next pending value: level bits follow the sampled source, edge bits
    // latch a rising edge and clear on W1C or acceptance, with a fresh edge
    // in the same cycle winning over the clear.
    always_comb begin
        rise      = src_q & ~prev;
        clr       = (wr_pend ? wdata : '0) | (taken_ok ? win_oh : '0);
        edge_next = rise | (pend & ~clr);
        pend_next = (mode & edge_next) | (~mode & src_q);
        eligible  = pend & ie;
    end

    // EOI retires the innermost handler before the newly taken source is
    // marked, so a same-cycle EOI and acceptance swap the top entry.
    always_comb begin
        isr_next = isr;
        if (wr_eoi) begin
            isr_next = isr_next & ~isr_low_oh;
        end
        if (taken_ok) begin
            isr_next = isr_next | win_oh;
        end
    end

    // Two-stage source sampling for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_q <= '0;
            prev  <= '0;
        end else begin
            src_q <= irq_in;
            prev  <= src_q;
        end
    end

    // Configuration registers written through the bridge.
    always_ff @(posedge clk) begin
        if (reset) begin
            ie   <= IE_RESET;
            mode <= '0;
        end else begin
            if (wr_ie) begin
                ie <= wdata;
            end
            if (wr_mode) begin
                mode <= wdata;
            end
        end
    end

    // Pending and in-service state.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend <= '0;
            isr  <= '0;
        end else begin
            pend <= pend_next;
            isr  <= isr_next;
        end
    end

    // Registered request vector: enabled pending sources that outrank
    // every handler currently in service.
    always_ff @(posedge clk) begin
        if (reset) begin
            hwint <= '0;
        end else begin
            hwint <= eligible & ~pmask;
        end
    end

    assign irq_req = |hwint;

    // Combinational read mux; unused bits read as zero.
    always_comb begin
        dout = '0;
        case (reg_sel)
            A_IE:   dout[N_SRC-1:0] = ie;
            A_MODE: dout[N_SRC-1:0] = mode;
            A_PEND: dout[N_SRC-1:0] = pend;
            A_ISR: begin
                dout[31]        = isr_any;
                dout[8 +: N_SRC] = isr;
                dout[2:0]       = isr_idx;
            end
            default: dout = '0;
        endcase
    end

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed scenarios plus randomized traffic for int_ctrl,
// checked against a per-source behavioural model of the controller.
module tb_int_ctrl;

    localparam int           N      = 6;
    localparam logic [N-1:0] IE_RST = 6'h15;

    logic          clk;
    logic          reset;
    logic [N-1:0]  irq_in;
    logic [29:0]   addr;
    logic          we;
    logic [31:0]   din;
    logic [31:0]   dout;
    logic          irq_taken;
    logic [N-1:0]  hwint;
    logic          irq_req;

    int total = 0;
    int bad   = 0;

    int_ctrl #(.N_SRC(N), .IE_RESET(IE_RST)) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_in    (irq_in),
        .addr      (addr),
        .we        (we),
        .din       (din),
        .dout      (dout),
        .irq_taken (irq_taken),
        .hwint     (hwint),
        .irq_req   (irq_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state, one entry per source.
    bit m_ie   [N];
    bit m_mode [N];
    bit m_pend [N];
    bit m_isr  [N];
    bit m_srcq [N];
    bit m_prev [N];
    bit m_hw   [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int first_of(input bit v [N]);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] pack(input bit v [N]);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i] = v[i];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input int a);
        logic [31:0] r;
        int          lo;
        r = '0;
        case (a)
            0: r = pack(m_ie);
            1: r = pack(m_mode);
            2: r = pack(m_pend);
            default: begin
                lo = first_of(m_isr);
                if (lo >= 0) begin
                    r        = pack(m_isr) << 8;
                    r[31]    = 1'b1;
                    r[2:0]   = 3'(lo);
                end
            end
        endcase
        return r;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_ie[i]   = IE_RST[i];
            m_mode[i] = 0; m_pend[i] = 0; m_isr[i] = 0;
            m_srcq[i] = 0; m_prev[i] = 0; m_hw[i] = 0;
        end
    endtask

    // Advance the model across one clock edge with the given inputs.
    task automatic m_clock(input logic [N-1:0] irq, input bit w, input int a,
                           input logic [31:0] d, input bit tk, input bit rs);
        bit n_pend [N];
        bit n_isr  [N];
        bit n_hw   [N];
        int win, lo;
        bit tk_ok, rise, cleared;
        if (rs) begin
            m_reset();
            return;
        end
        win   = first_of(m_hw);
        tk_ok = tk && (win >= 0);
        lo    = first_of(m_isr);
        for (int i = 0; i < N; i++) begin
            if (m_mode[i]) begin
                rise      = m_srcq[i] && !m_prev[i];
                cleared   = (w && a == 2 && d[i]) || (tk_ok && win == i);
                n_pend[i] = rise || (m_pend[i] && !cleared);
            end else begin
                n_pend[i] = m_srcq[i];
            end
            n_isr[i] = m_isr[i];
            n_hw[i]  = m_pend[i] && m_ie[i] && !(lo >= 0 && i >= lo);
        end
        if (w && a == 3 && lo >= 0) n_isr[lo] = 0;
        if (tk_ok) n_isr[win] = 1;
        for (int i = 0; i < N; i++) begin
            m_pend[i] = n_pend[i];
            m_isr[i]  = n_isr[i];
            m_hw[i]   = n_hw[i];
            m_prev[i] = m_srcq[i];
            m_srcq[i] = irq[i];
            if (w && a == 0) m_ie[i] = d[i];
            if (w && a == 1) m_mode[i] = d[i];
        end
    endtask

    // One cycle: drive at the falling edge, compare, then clock both.
    task automatic step(input logic [N-1:0] irq, input bit w, input int a,
                        input logic [31:0] d, input bit tk, input bit rs);
        logic [31:0] exp_hw;
        irq_in    = irq;
        we        = w;
        addr      = 30'(a);
        din       = d;
        irq_taken = tk;
        reset     = rs;
        #1;
        exp_hw = pack(m_hw);
        check("dout", dout, m_read(a));
        check("hwint", 32'(hwint), exp_hw);
        check("irq_req", 32'(irq_req), 32'(exp_hw != 0));
        m_clock(irq, w, a, d, tk, rs);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic peek(input string tag, input int a, input logic [31:0] exp);
        we        = 1'b0;
        irq_taken = 1'b0;
        addr      = 30'(a);
        #1;
        check(tag, dout, exp);
    endtask

    initial begin
        logic [N-1:0] irq;
        bit           w, tk, rs;
        int           a;
        logic [31:0]  d;

        reset = 1'b1; irq_in = '0; addr = '0; we = 1'b0; din = '0; irq_taken = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_reset();
        peek("rst_ie", 0, 32'(IE_RST));
        peek("rst_mode", 1, 32'h0);
        peek("rst_pend", 2, 32'h0);
        peek("rst_isr", 3, 32'h0);
        check("rst_hwint", 32'(hwint), 32'h0);
        check("rst_req", 32'(irq_req), 32'h0);

        // Level latency: src_q, pend, hwint on three successive edges.
        step(6'h00, 1, 0, 32'h03, 0, 0);
        step(6'h02, 0, 0, 0, 0, 0);
        check("lat_k", 32'(hwint), 32'h0);
        step(6'h02, 0, 0, 0, 0, 0);
        check("lat_k1", 32'(hwint), 32'h0);
        step(6'h02, 0, 0, 0, 0, 0);
        check("lat_k2", 32'(hwint), 32'h02);
        check("lat_req", 32'(irq_req), 32'h1);
        repeat (3) step(6'h00, 0, 0, 0, 0, 0);
        check("lat_drop", 32'(hwint), 32'h0);

        // Two pending sources; take the winner, then EOI.
        step(6'h0A, 1, 0, 32'h0A, 0, 0);
        step(6'h0A, 0, 0, 0, 0, 0);
        step(6'h0A, 0, 0, 0, 0, 0);
        check("two_hw", 32'(hwint), 32'h0A);
        step(6'h0A, 0, 3, 0, 1, 0);
        peek("take_isr", 3, 32'h8000_0201);
        step(6'h0A, 0, 3, 0, 0, 0);
        check("take_mask", 32'(hwint), 32'h0);
        step(6'h0A, 1, 3, 0, 0, 0);
        peek("eoi_isr", 3, 32'h0);
        step(6'h0A, 0, 3, 0, 0, 0);
        check("eoi_hw", 32'(hwint), 32'h0A);
        repeat (3) step(6'h00, 0, 0, 0, 0, 0);

        // Edge source: pulse, then a W1C colliding with a new rising edge.
        step(6'h00, 1, 1, 32'h04, 0, 0);
        step(6'h00, 1, 0, 32'h04, 0, 0);
        step(6'h04, 0, 2, 0, 0, 0);
        step(6'h00, 0, 2, 0, 0, 0);
        step(6'h04, 0, 2, 0, 0, 0);
        peek("edge_pend", 2, 32'h04);
        check("edge_hw", 32'(hwint), 32'h04);
        step(6'h00, 1, 2, 32'h04, 0, 0);
        peek("w1c_race", 2, 32'h04);
        step(6'h00, 1, 2, 32'h04, 0, 0);
        peek("w1c_clr", 2, 32'h0);
        step(6'h00, 0, 2, 0, 0, 0);
        check("w1c_hw", 32'(hwint), 32'h0);

        // Reset while a handler is in service.
        step(6'h08, 1, 0, 32'h3F, 0, 0);
        step(6'h08, 0, 0, 0, 0, 0);
        step(6'h08, 0, 0, 0, 0, 0);
        step(6'h08, 0, 3, 0, 1, 0);
        peek("svc_isr", 3, 32'h8000_0803);
        step(6'h08, 0, 3, 0, 0, 1);
        peek("mid_isr", 3, 32'h0);
        peek("mid_pend", 2, 32'h0);
        peek("mid_ie", 0, 32'(IE_RST));
        check("mid_hw", 32'(hwint), 32'h0);

        // Randomized traffic against the model.
        irq = '0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(7) == 0) irq[i] = ~irq[i];
            w  = ($urandom_range(3) == 0);
            a  = int'($urandom_range(3));
            d  = $urandom;
            if (w && a == 0 && $urandom_range(1) == 0) d[N-1:0] = '1;
            tk = ($urandom_range(2) == 0);
            rs = ($urandom_range(299) == 0);
            step(irq, w, a, d, tk, rs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
